// File: rtl/pagerank_scatter_if.sv
// pagerank_scatter_if: scatter output stream towards the gather accumulator.
// Handshake: pagerank_ready is a one-cycle valid strobe with no back-pressure;
// page_rank_scatter/dest_id are meaningful only while pagerank_ready is 1 and
// the consumer must take the beat in that cycle. scatter_operation_complete
// is a level that stays high once the pass has fully drained.
interface pagerank_scatter_if;
    logic [63:0] page_rank_scatter;
    logic [31:0] dest_id;
    logic        pagerank_ready;
    logic        scatter_operation_complete;

    modport master (
        output page_rank_scatter,
        output dest_id,
        output pagerank_ready,
        output scatter_operation_complete
    );

    modport slave (
        input page_rank_scatter,
        input dest_id,
        input pagerank_ready,
        input scatter_operation_complete
    );
endinterface

// File: rtl/pagerank_scatter.sv
// pagerank_scatter: scatter phase of one PageRank iteration.
// Streams edges from an external edge memory (one read per enabled cycle),
// looks up the source node's contribution and emits {contribution, dest}
// beats on the scatter interface, then raises scatter_operation_complete.
// Pipeline: read issued in cycle t, edge data back in t+1, registered beat
// visible in t+2. A 1-entry skid register catches the edge returning while
// paused so nothing is lost across pagerank_enable=0.
// Build option: define SCATTER_COMBINE_EN to merge consecutive in-range edges
// with the same dest_id into one summed beat; without it there is no adder.
module pagerank_scatter #(
    parameter int NODES_IN_GRAPH = 32,
    parameter int EDGES_IN_GRAPH = 128,
    parameter int EDGE_ADDR_W    = $clog2(EDGES_IN_GRAPH)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   pagerank_enable,
    input  logic                   nextIteration,
    input  logic [EDGE_ADDR_W:0]   num_edges,
    output logic                   edge_rd_en,
    output logic [EDGE_ADDR_W-1:0] edge_rd_addr,
    input  logic [63:0]            edge_rd_data,
    input  logic [63:0]            node_contrib [NODES_IN_GRAPH],
    pagerank_scatter_if.master     scat,
    output logic [15:0]            dropped_edges,
    output logic [1:0]             dbg_state
);

    localparam int CNT_W  = EDGE_ADDR_W + 1;
    localparam int NODE_W = (NODES_IN_GRAPH > 1) ? $clog2(NODES_IN_GRAPH) : 1;
    localparam logic [31:0]      NODES_LIM = 32'(NODES_IN_GRAPH);
    localparam logic [CNT_W-1:0] EDGES_LIM = CNT_W'(EDGES_IN_GRAPH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Control state
    state_t           state_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] num_q;
    logic             complete_q;
    logic             restart_pend_q;

    // Datapath state
    logic        rd_pend_q,  rd_pend_d;
    logic        skid_v_q,   skid_v_d;
    logic [63:0] skid_q,     skid_d;
    logic        out_v_q,    out_v_d;
    logic [63:0] out_data_q, out_data_d;
    logic [31:0] out_dest_q, out_dest_d;
    logic [15:0] dropped_q,  dropped_d;

`ifdef SCATTER_COMBINE_EN
    logic        acc_v_q,    acc_v_d;
    logic [63:0] acc_sum_q,  acc_sum_d;
    logic [31:0] acc_dest_q, acc_dest_d;
`endif

    // Edge being looked at this cycle: the skid entry is always older
    logic [63:0] proc_edge;
    logic [31:0] proc_src;
    logic [31:0] proc_dest;
    logic        proc_in_range;
    logic [63:0] proc_contrib;
    logic        proc_v;

    logic             start_take;
    logic [CNT_W-1:0] num_eff;
    logic             drained;

    // A restart is only acted on while enabled; one seen while paused waits
    assign start_take = pagerank_enable && (nextIteration || restart_pend_q);
    assign num_eff    = (num_edges > EDGES_LIM) ? EDGES_LIM : num_edges;

`ifdef SCATTER_COMBINE_EN
    assign drained = !rd_pend_q && !skid_v_q && !acc_v_q;
`else
    assign drained = !rd_pend_q && !skid_v_q;
`endif

    assign edge_rd_en   = (state_q == S_RUN) && pagerank_enable;
    assign edge_rd_addr = rd_cnt_q[EDGE_ADDR_W-1:0];

    assign scat.page_rank_scatter          = out_data_q;
    assign scat.dest_id                    = out_dest_q;
    assign scat.pagerank_ready             = out_v_q && pagerank_enable;
    assign scat.scatter_operation_complete = complete_q;
    assign dropped_edges                   = dropped_q;
    assign dbg_state                       = state_q;

    // Pass control: read issue counter, drain detection and completion flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            rd_cnt_q       <= '0;
            num_q          <= '0;
            complete_q     <= 1'b0;
            restart_pend_q <= 1'b0;
        end else begin
            if (nextIteration && !pagerank_enable) begin
                restart_pend_q <= 1'b1;
            end else if (start_take) begin
                restart_pend_q <= 1'b0;
            end

            if (start_take) begin
                rd_cnt_q <= '0;
                num_q    <= num_eff;
                if (num_eff == '0) begin
                    state_q    <= S_DONE;
                    complete_q <= 1'b1;
                end else begin
                    state_q    <= S_RUN;
                    complete_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_RUN: begin
                        if (pagerank_enable) begin
                            rd_cnt_q <= rd_cnt_q + 1'b1;
                            if (rd_cnt_q + 1'b1 == num_q) begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (pagerank_enable && drained) begin
                            state_q    <= S_DONE;
                            complete_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Decode the candidate edge and fetch its source contribution
    always_comb begin
        proc_edge     = skid_v_q ? skid_q : edge_rd_data;
        proc_src      = proc_edge[63:32];
        proc_dest     = proc_edge[31:0];
        proc_in_range = (proc_src < NODES_LIM) && (proc_dest < NODES_LIM);
        proc_contrib  = node_contrib[proc_src[NODE_W-1:0]];
    end

    // Next-state for skid, range check, optional combining and output beat
    always_comb begin
        rd_pend_d  = edge_rd_en;
        skid_v_d   = skid_v_q;
        skid_d     = skid_q;
        // A beat shown while enabled is consumed; while paused it is held
        out_v_d    = out_v_q && !pagerank_enable;
        out_data_d = out_data_q;
        out_dest_d = out_dest_q;
        dropped_d  = dropped_q;
        proc_v     = 1'b0;
`ifdef SCATTER_COMBINE_EN
        acc_v_d    = acc_v_q;
        acc_sum_d  = acc_sum_q;
        acc_dest_d = acc_dest_q;
`endif
        if (start_take) begin
            // Everything in flight belongs to the abandoned pass
            rd_pend_d = 1'b0;
            skid_v_d  = 1'b0;
            out_v_d   = 1'b0;
            dropped_d = '0;
`ifdef SCATTER_COMBINE_EN
            acc_v_d   = 1'b0;
`endif
        end else if (!pagerank_enable) begin
            if (rd_pend_q) begin
                skid_v_d = 1'b1;
                skid_d   = edge_rd_data;
            end
        end else begin
            if (skid_v_q) begin
                proc_v   = 1'b1;
                skid_v_d = rd_pend_q;
                skid_d   = edge_rd_data;
            end else if (rd_pend_q) begin
                proc_v = 1'b1;
            end

            if (proc_v && !proc_in_range) begin
                if (dropped_q != 16'hFFFF) begin
                    dropped_d = dropped_q + 1'b1;
                end
            end else if (proc_v) begin
`ifdef SCATTER_COMBINE_EN
                if (acc_v_q && (acc_dest_q == proc_dest)) begin
                    acc_sum_d = acc_sum_q + proc_contrib;
                end else begin
                    if (acc_v_q) begin
                        out_v_d    = 1'b1;
                        out_data_d = acc_sum_q;
                        out_dest_d = acc_dest_q;
                    end
                    acc_v_d    = 1'b1;
                    acc_sum_d  = proc_contrib;
                    acc_dest_d = proc_dest;
                end
`else
                out_v_d    = 1'b1;
                out_data_d = proc_contrib;
                out_dest_d = proc_dest;
`endif
            end
`ifdef SCATTER_COMBINE_EN
            else if (acc_v_q && (state_q == S_DRAIN)) begin
                // No more edges can arrive: flush the open run
                out_v_d    = 1'b1;
                out_data_d = acc_sum_q;
                out_dest_d = acc_dest_q;
                acc_v_d    = 1'b0;
            end
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_q  <= 1'b0;
            skid_v_q   <= 1'b0;
            skid_q     <= '0;
            out_v_q    <= 1'b0;
            out_data_q <= '0;
            out_dest_q <= '0;
            dropped_q  <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            skid_v_q   <= skid_v_d;
            skid_q     <= skid_d;
            out_v_q    <= out_v_d;
            out_data_q <= out_data_d;
            out_dest_q <= out_dest_d;
            dropped_q  <= dropped_d;
        end
    end

`ifdef SCATTER_COMBINE_EN
    // Run accumulator for same-destination merging
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_v_q    <= 1'b0;
            acc_sum_q  <= '0;
            acc_dest_q <= '0;
        end else begin
            acc_v_q    <= acc_v_d;
            acc_sum_q  <= acc_sum_d;
            acc_dest_q <= acc_dest_d;
        end
    end
`endif

endmodule

// File: tb/tb_pagerank_scatter.sv
// tb_pagerank_scatter: self-checking bench for pagerank_scatter.
// Expected beats come from a small reference model over the bench's own edge
// table and contribution array; they are queued at stimulus time and popped
// by the output monitor.
module tb_pagerank_scatter;

    localparam int NODES = 32;
    localparam int EDGES = 128;
    localparam int AW    = 7;

`ifdef SCATTER_COMBINE_EN
    localparam int LAT_FIRST = 4;
`else
    localparam int LAT_FIRST = 2;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clock           = 1'b0;
    logic          reset_n         = 1'b0;
    logic          pagerank_enable = 1'b1;
    logic          nextIteration   = 1'b0;
    logic [AW:0]   num_edges       = '0;
    logic          edge_rd_en;
    logic [AW-1:0] edge_rd_addr;
    logic [63:0]   edge_rd_data    = '0;
    logic [63:0]   node_contrib [NODES];
    logic [15:0]   dropped_edges;
    logic [1:0]    dbg_state;
    logic [63:0]   edge_mem [EDGES];

    pagerank_scatter_if scat ();

    pagerank_scatter #(
        .NODES_IN_GRAPH (NODES),
        .EDGES_IN_GRAPH (EDGES)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .pagerank_enable (pagerank_enable),
        .nextIteration   (nextIteration),
        .num_edges       (num_edges),
        .edge_rd_en      (edge_rd_en),
        .edge_rd_addr    (edge_rd_addr),
        .edge_rd_data    (edge_rd_data),
        .node_contrib    (node_contrib),
        .scat            (scat.master),
        .dropped_edges   (dropped_edges),
        .dbg_state       (dbg_state)
    );

    always #5 clock = ~clock;

    // Edge memory: one-cycle read latency
    always @(posedge clock) begin
        if (edge_rd_en) edge_rd_data <= edge_mem[edge_rd_addr];
    end

    // ---------------- scoreboard ----------------
    logic [95:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int   cyc = 0;
    int   rd_count, pulse_cnt, first_rd, first_pulse, last_pulse, complete_rise;
    int   start_cyc;
    logic complete_prev = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        logic [95:0] e;
        if (reset_n) begin
            if (edge_rd_en) begin
                if (first_rd < 0) first_rd = cyc;
                rd_count++;
            end
            if (!pagerank_enable) check("ready_while_paused", scat.pagerank_ready, 0);
            if (scat.pagerank_ready) begin
                pulse_cnt++;
                if (first_pulse < 0) first_pulse = cyc;
                last_pulse = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse", {scat.dest_id, scat.page_rank_scatter}, e);
                end
            end
            if (scat.scatter_operation_complete && !complete_prev) complete_rise = cyc;
        end
        complete_prev = scat.scatter_operation_complete;
    end

    // ---------------- model and driver tasks ----------------
    task automatic set_common();
        for (int i = 0; i < NODES; i++)
            node_contrib[i] = (i < 4) ? 64'((i + 1) * 10) : 64'(1000 + i);
        for (int i = 0; i < EDGES; i++) edge_mem[i] = {32'd5, 32'd6};
        edge_mem[0] = {32'd0, 32'd1};
        edge_mem[1] = {32'd2, 32'd1};
        edge_mem[2] = {32'd1, 32'd3};
        edge_mem[3] = {32'd3, 32'd0};
    endtask

    task automatic build_expect(input int n, output int drops);
        logic [63:0] e;
        logic [31:0] s, d;
`ifdef SCATTER_COMBINE_EN
        logic        have;
        logic [31:0] run_d;
        logic [63:0] run_s;
        have  = 1'b0;
        run_d = '0;
        run_s = '0;
`endif
        drops = 0;
        for (int i = 0; i < n; i++) begin
            e = edge_mem[i];
            s = e[63:32];
            d = e[31:0];
            if (s >= NODES || d >= NODES) begin
                drops++;
            end else begin
`ifdef SCATTER_COMBINE_EN
                if (have && d == run_d) begin
                    run_s = run_s + node_contrib[s[4:0]];
                end else begin
                    if (have) exp_q.push_back({run_d, run_s});
                    have  = 1'b1;
                    run_d = d;
                    run_s = node_contrib[s[4:0]];
                end
`else
                exp_q.push_back({d, node_contrib[s[4:0]]});
`endif
            end
        end
`ifdef SCATTER_COMBINE_EN
        if (have) exp_q.push_back({run_d, run_s});
`endif
    endtask

    task automatic reset_trackers();
        rd_count      = 0;
        pulse_cnt     = 0;
        first_rd      = -1;
        first_pulse   = -1;
        last_pulse    = -1;
        complete_rise = -1;
    endtask

    task automatic start_pass(input int n);
        @(posedge clock);
        #1;
        reset_trackers();
        start_cyc     = cyc;
        num_edges     = (AW + 1)'(n);
        nextIteration = 1'b1;
        @(posedge clock);
        #1;
        nextIteration = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int pause_at);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clock);
            #1;
            if (scat.scatter_operation_complete) begin
                done = 1'b1;
            end else if (pause_at > 0 && pulse_cnt >= pause_at) begin
                pause_at = 0;
                @(posedge clock);
                #1;
                pagerank_enable = 1'b0;
                repeat (3) @(posedge clock);
                #1;
                pagerank_enable = 1'b1;
            end
        end
        check({tag, "_completes"}, done, 1);
    endtask

    task automatic end_checks(input string tag, input int n_exp, input int drops);
        check({tag, "_pulse_count"}, pulse_cnt, n_exp);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_dropped"}, dropped_edges, drops);
        check({tag, "_complete_after_last"}, complete_rise, last_pulse + 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int drops, n_exp;
        bit seen;
        set_common();
        reset_trackers();
        num_edges = 5'd4;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rd_en", edge_rd_en, 0);
        check("rst_rd_addr", edge_rd_addr, 0);
        check("rst_ready", scat.pagerank_ready, 0);
        check("rst_data", scat.page_rank_scatter, 0);
        check("rst_dest", scat.dest_id, 0);
        check("rst_complete", scat.scatter_operation_complete, 0);
        check("rst_dropped", dropped_edges, 0);
        check("rst_state", dbg_state, 0);
        reset_n = 1'b1;

        // Basic pass
        build_expect(4, drops);
        n_exp = exp_q.size();
        start_pass(4);
        wait_done("t1", 0);
        end_checks("t1", n_exp, drops);
        check("t1_reads", rd_count, 4);
        check("t1_first_latency", first_pulse - first_rd, LAT_FIRST);
        repeat (3) @(posedge clock);
        #1;
        check("t1_complete_held", scat.scatter_operation_complete, 1);
        check("t1_no_extra_reads", rd_count, 4);
        check("t1_state_done", dbg_state, 3);

        // Pause for 3 cycles after the 2nd beat
        build_expect(4, drops);
        n_exp = exp_q.size();
        start_pass(4);
        wait_done("t2", 2);
        end_checks("t2", n_exp, drops);

        // Out-of-range source on the 3rd edge
        edge_mem[2] = {32'd40, 32'd3};
        build_expect(4, drops);
        n_exp = exp_q.size();
        start_pass(4);
        wait_done("t4", 0);
        end_checks("t4", n_exp, drops);
        check("t4_dropped_one", dropped_edges, 1);
        edge_mem[2] = {32'd1, 32'd3};

        // Restart while the 3rd read is being issued
`ifndef SCATTER_COMBINE_EN
        exp_q.push_back({32'd1, 64'd10});
`endif
        build_expect(4, drops);
        n_exp = exp_q.size();
        start_pass(4);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clock);
            #1;
            if (rd_count >= 2) seen = 1'b1;
        end
        check("t5_two_reads_seen", seen, 1);
        @(posedge clock);
        #1;
        nextIteration = 1'b1;
        @(posedge clock);
        #1;
        nextIteration = 1'b0;
        wait_done("t5", 0);
        end_checks("t5", n_exp, drops);

        // Asynchronous reset in the middle of a pass
        start_pass(4);
        #3;
        reset_n = 1'b0;
        #1;
        check("t5r_rd_en", edge_rd_en, 0);
        check("t5r_rd_addr", edge_rd_addr, 0);
        check("t5r_ready", scat.pagerank_ready, 0);
        check("t5r_data", scat.page_rank_scatter, 0);
        check("t5r_dest", scat.dest_id, 0);
        check("t5r_complete", scat.scatter_operation_complete, 0);
        check("t5r_state", dbg_state, 0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Empty pass
        start_pass(0);
        repeat (3) @(posedge clock);
        #1;
        check("t3_complete_rise", complete_rise, start_cyc + 1);
        check("t3_complete_level", scat.scatter_operation_complete, 1);
        check("t3_reads", rd_count, 0);
        check("t3_pulses", pulse_cnt, 0);

        // Restart requested while paused is taken on resume
        build_expect(4, drops);
        n_exp = exp_q.size();
        @(posedge clock);
        #1;
        reset_trackers();
        num_edges       = 5'd4;
        pagerank_enable = 1'b0;
        nextIteration   = 1'b1;
        @(posedge clock);
        #1;
        nextIteration = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("t7_no_reads_paused", rd_count, 0);
        pagerank_enable = 1'b1;
        @(posedge clock);
        #1;
        check("t7_complete_cleared", scat.scatter_operation_complete, 0);
        wait_done("t7", 0);
        end_checks("t7", n_exp, drops);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
